// File: rtl/hbuf_ctrl.sv
// hbuf_ctrl -- hit-buffer controller.
//
// Copies variable-length records from an internal 1024x32 readout DPRAM into
// a 4 KiB (1024x32) page buffer. A full page, or a partial page on flush, is
// handed to DDR3 through a req/ack page port. The controller manages a ring
// of DDR3 pages [first_pg..last_pg] with read/write pointers and host clears.
//
// Ports
//   clk_i, rst_ni              clock (rising edge), async active-low reset
//   en_i                       ring enable; rising edge latches the bounds
//   start_pg_i, stop_pg_i      ring bounds to latch (stop >= start)
//   first_pg_o, last_pg_o      latched ring bounds
//   flush_req_i, flush_ack_o   commit partial page / 1-cycle ack pulse
//   empty_o, full_o            no committed pages / ring completely used
//   rd_pg_num_o, wr_pg_num_o   oldest unread page / next page to write
//   n_used_pgs_o               committed, uncleared pages
//   pg_clr_cnt_i               number of pages to release
//   pg_clr_req_i, pg_clr_ack_o clear request / 1-cycle ack pulse
//   buffered_data_o            page buffer holds uncommitted words
//   dpram_len_i                record length in words (1..1024)
//   rdout_dpram_run_i          1-cycle pulse: copy one record
//   dpram_busy_o               copy in progress
//   rdout_dpram_wren_i/_wr_addr_i/_data_i  readout DPRAM write port
//   ddr3_dpram_rd_addr_i       page buffer read address (128-bit words)
//   ddr3_dpram_dout_o          page buffer data, word 4k+i at [32i+31:32i]
//   pg_req_o, pg_ack_i         page transfer handshake
//   pg_optype_o                1 = write to DDR3
//   pg_addr_o                  {wr_pg_num, 12'h000}
//   dbg_state_o                copy FSM state
//
// Handshake: pg_req_o rises with pg_addr_o/pg_optype_o and holds them
// stable until pg_ack_i is sampled high; pg_req_o drops the following cycle.
// pg_ack_i is ignored while pg_req_o is low.

module hbuf_ctrl #(
  parameter int P_PG_WORDS = 1024
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         en_i,
  input  logic [15:0]  start_pg_i,
  input  logic [15:0]  stop_pg_i,
  output logic [15:0]  first_pg_o,
  output logic [15:0]  last_pg_o,
  input  logic         flush_req_i,
  output logic         flush_ack_o,
  output logic         empty_o,
  output logic         full_o,
  output logic [15:0]  rd_pg_num_o,
  output logic [15:0]  wr_pg_num_o,
  output logic [15:0]  n_used_pgs_o,
  input  logic [15:0]  pg_clr_cnt_i,
  input  logic         pg_clr_req_i,
  output logic         pg_clr_ack_o,
  output logic         buffered_data_o,
  input  logic [15:0]  dpram_len_i,
  input  logic         rdout_dpram_run_i,
  output logic         dpram_busy_o,
  input  logic         rdout_dpram_wren_i,
  input  logic [9:0]   rdout_dpram_wr_addr_i,
  input  logic [31:0]  rdout_dpram_data_i,
  input  logic [7:0]   ddr3_dpram_rd_addr_i,
  output logic [127:0] ddr3_dpram_dout_o,
  output logic         pg_req_o,
  input  logic         pg_ack_i,
  output logic         pg_optype_o,
  output logic [27:0]  pg_addr_o,
  output logic [2:0]   dbg_state_o
);

  // Address widths below are sized for a 1024-word page.
  localparam logic [10:0] PG_WORDS_L = 11'(P_PG_WORDS);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_COPY   = 3'd1,
    ST_COMMIT = 3'd2,
    ST_FLUSH  = 3'd3,
    ST_DROP   = 3'd4
  } state_e;

  state_e state_q, state_d;

  logic [10:0] len_q, len_d;
  logic [10:0] issue_cnt_q, issue_cnt_d;
  logic [10:0] fill_q, fill_d;
  logic        rd_vld_q;
  logic [31:0] rdo_dout_q;

  logic        pg_req_q, pg_req_d;
  logic        pg_optype_q, pg_optype_d;
  logic [27:0] pg_addr_q, pg_addr_d;
  logic        flush_ack_q, flush_ack_d;
  logic        flush_armed_q, flush_armed_d;
  logic        clr_ack_q, clr_ack_d;
  logic        clr_armed_q, clr_armed_d;

  logic        en_q;
  logic [15:0] first_pg_q, first_pg_d;
  logic [15:0] last_pg_q, last_pg_d;
  logic [15:0] rd_pg_q, rd_pg_d;
  logic [15:0] wr_pg_q, wr_pg_d;
  logic [15:0] n_used_q, n_used_d;
  logic        empty_q, full_q;
  logic [127:0] dout_q;

  logic [31:0] rdo_mem [1024];
  logic [31:0] pbuf    [1024];

  logic        issue;
  logic        commit;
  logic [10:0] fill_land;
  logic        en_rise;
  logic        clr_go;
  logic [15:0] clr_k;
  logic [16:0] ring_sz;
  logic [16:0] rd_sum;
  logic [16:0] rd_wrap;
  logic [15:0] n_next;

  logic unused_len_bits;
  assign unused_len_bits = ^dpram_len_i[15:11];

  // ---------------------------------------------------------------------------
  // Copy FSM and page commit
  // ---------------------------------------------------------------------------
  assign fill_land = fill_q + {10'd0, rd_vld_q};

  // A read is only issued if the word (plus any word still in flight) fits in
  // the current page, so the page never overflows.
  assign issue = (state_q == ST_COPY) && (issue_cnt_q != len_q) &&
                 (fill_land < PG_WORDS_L);

  always_comb begin
    state_d       = state_q;
    len_d         = len_q;
    issue_cnt_d   = issue_cnt_q;
    fill_d        = fill_q;
    pg_req_d      = pg_req_q;
    pg_optype_d   = pg_optype_q;
    pg_addr_d     = pg_addr_q;
    flush_ack_d   = 1'b0;
    flush_armed_d = flush_armed_q;
    commit        = 1'b0;

    if (!flush_req_i) flush_armed_d = 1'b1;

    unique case (state_q)
      ST_IDLE: begin
        if (rdout_dpram_run_i) begin
          if (en_i) begin
            len_d       = dpram_len_i[10:0];
            issue_cnt_d = '0;
            state_d     = ST_COPY;
          end else begin
            state_d     = ST_DROP;
          end
        end else if (flush_req_i && flush_armed_q) begin
          flush_armed_d = 1'b0;
          if (fill_q != '0) state_d = ST_FLUSH;
          else              flush_ack_d = 1'b1;
        end
      end

      ST_COPY: begin
        fill_d = fill_land;
        if (issue) issue_cnt_d = issue_cnt_q + 11'd1;
        if (fill_land == PG_WORDS_L)  state_d = ST_COMMIT;
        else if (issue_cnt_q == len_q) state_d = ST_IDLE;
      end

      ST_COMMIT, ST_FLUSH: begin
        if (pg_req_q) begin
          if (pg_ack_i) begin
            pg_req_d = 1'b0;
            commit   = 1'b1;
            fill_d   = '0;
            if (state_q == ST_FLUSH) begin
              flush_ack_d = 1'b1;
              state_d     = ST_IDLE;
            end else if (issue_cnt_q == len_q) begin
              state_d     = ST_IDLE;
            end else begin
              state_d     = ST_COPY;
            end
          end
        end else if (!full_q) begin
          // Wait here without requesting while the ring has no free slot.
          pg_req_d    = 1'b1;
          pg_optype_d = 1'b1;
          pg_addr_d   = {wr_pg_q, 12'h000};
        end
      end

      ST_DROP: state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Ring pointers, page clear
  // ---------------------------------------------------------------------------
  assign en_rise = en_i & ~en_q;
  assign clr_go  = pg_clr_req_i & clr_armed_q;
  assign clr_k   = (pg_clr_cnt_i < n_used_q) ? pg_clr_cnt_i : n_used_q;
  assign ring_sz = {1'b0, last_pg_q} - {1'b0, first_pg_q} + 17'd1;
  assign rd_sum  = {1'b0, rd_pg_q} + {1'b0, clr_k};
  // k never exceeds the ring size, so one subtraction is enough to wrap.
  assign rd_wrap = (rd_sum > {1'b0, last_pg_q}) ? (rd_sum - ring_sz) : rd_sum;

  always_comb begin
    first_pg_d  = first_pg_q;
    last_pg_d   = last_pg_q;
    rd_pg_d     = rd_pg_q;
    wr_pg_d     = wr_pg_q;
    n_used_d    = n_used_q;
    clr_ack_d   = 1'b0;
    clr_armed_d = clr_armed_q;
    n_next      = n_used_q;

    if (!pg_clr_req_i) clr_armed_d = 1'b1;
    if (clr_go) begin
      clr_armed_d = 1'b0;
      clr_ack_d   = 1'b1;
    end

    if (en_rise) begin
      first_pg_d = start_pg_i;
      last_pg_d  = stop_pg_i;
      rd_pg_d    = start_pg_i;
      wr_pg_d    = start_pg_i;
      n_used_d   = '0;
    end else begin
      // Clear and commit in the same cycle net out to old - k + 1.
      if (clr_go) begin
        n_next  = n_next - clr_k;
        rd_pg_d = rd_wrap[15:0];
      end
      if (commit) begin
        n_next  = n_next + 16'd1;
        wr_pg_d = (wr_pg_q == last_pg_q) ? first_pg_q : (wr_pg_q + 16'd1);
      end
      n_used_d = n_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= ST_IDLE;
      len_q         <= '0;
      issue_cnt_q   <= '0;
      fill_q        <= '0;
      rd_vld_q      <= 1'b0;
      pg_req_q      <= 1'b0;
      pg_optype_q   <= 1'b0;
      pg_addr_q     <= '0;
      flush_ack_q   <= 1'b0;
      flush_armed_q <= 1'b1;
      clr_ack_q     <= 1'b0;
      clr_armed_q   <= 1'b1;
      en_q          <= 1'b0;
      first_pg_q    <= '0;
      last_pg_q     <= '0;
      rd_pg_q       <= '0;
      wr_pg_q       <= '0;
      n_used_q      <= '0;
      empty_q       <= 1'b0;
      full_q        <= 1'b0;
      dout_q        <= '0;
    end else begin
      state_q       <= state_d;
      len_q         <= len_d;
      issue_cnt_q   <= issue_cnt_d;
      fill_q        <= fill_d;
      rd_vld_q      <= issue;
      pg_req_q      <= pg_req_d;
      pg_optype_q   <= pg_optype_d;
      pg_addr_q     <= pg_addr_d;
      flush_ack_q   <= flush_ack_d;
      flush_armed_q <= flush_armed_d;
      clr_ack_q     <= clr_ack_d;
      clr_armed_q   <= clr_armed_d;
      en_q          <= en_i;
      first_pg_q    <= first_pg_d;
      last_pg_q     <= last_pg_d;
      rd_pg_q       <= rd_pg_d;
      wr_pg_q       <= wr_pg_d;
      n_used_q      <= n_used_d;
      empty_q       <= (n_used_d == '0);
      full_q        <= ~en_rise & ({1'b0, n_used_d} == ring_sz);
      dout_q        <= {pbuf[{ddr3_dpram_rd_addr_i, 2'd3}],
                        pbuf[{ddr3_dpram_rd_addr_i, 2'd2}],
                        pbuf[{ddr3_dpram_rd_addr_i, 2'd1}],
                        pbuf[{ddr3_dpram_rd_addr_i, 2'd0}]};
    end
  end

  // Memories: readout DPRAM (1-cycle read) and page buffer write side.
  always_ff @(posedge clk_i) begin
    if (rdout_dpram_wren_i) rdo_mem[rdout_dpram_wr_addr_i] <= rdout_dpram_data_i;
    rdo_dout_q <= rdo_mem[issue_cnt_q[9:0]];
    if ((state_q == ST_COPY) && rd_vld_q) pbuf[fill_q[9:0]] <= rdo_dout_q;
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign first_pg_o        = first_pg_q;
  assign last_pg_o         = last_pg_q;
  assign flush_ack_o       = flush_ack_q;
  assign empty_o           = empty_q;
  assign full_o            = full_q;
  assign rd_pg_num_o       = rd_pg_q;
  assign wr_pg_num_o       = wr_pg_q;
  assign n_used_pgs_o      = n_used_q;
  assign pg_clr_ack_o      = clr_ack_q;
  assign buffered_data_o   = (fill_q != '0);
  assign dpram_busy_o      = (state_q != ST_IDLE);
  assign ddr3_dpram_dout_o = dout_q;
  assign pg_req_o          = pg_req_q;
  assign pg_optype_o       = pg_optype_q;
  assign pg_addr_o         = pg_addr_q;
  assign dbg_state_o       = state_q;

endmodule

// File: tb/tb_hbuf_ctrl.sv
// Directed testbench for hbuf_ctrl: ring setup, page commits with wrap,
// full stall, page clear (single and clamped), flush, discard while disabled
// and page buffer readback.

module tb_hbuf_ctrl;

  logic         clk_i = 1'b0;
  logic         rst_ni;
  logic         en_i;
  logic [15:0]  start_pg_i, stop_pg_i;
  logic [15:0]  first_pg_o, last_pg_o;
  logic         flush_req_i, flush_ack_o;
  logic         empty_o, full_o;
  logic [15:0]  rd_pg_num_o, wr_pg_num_o, n_used_pgs_o;
  logic [15:0]  pg_clr_cnt_i;
  logic         pg_clr_req_i, pg_clr_ack_o;
  logic         buffered_data_o;
  logic [15:0]  dpram_len_i;
  logic         rdout_dpram_run_i, dpram_busy_o;
  logic         rdout_dpram_wren_i;
  logic [9:0]   rdout_dpram_wr_addr_i;
  logic [31:0]  rdout_dpram_data_i;
  logic [7:0]   ddr3_dpram_rd_addr_i;
  logic [127:0] ddr3_dpram_dout_o;
  logic         pg_req_o, pg_ack_i, pg_optype_o;
  logic [27:0]  pg_addr_o;
  logic [2:0]   dbg_state_o;

  int n_cmp  = 0;
  int n_fail = 0;

  // Expected DDR3 page addresses, in commit order.
  logic [27:0] exp_q[$];

  localparam logic [31:0] RAMP_BASE = 32'hA500_0000;

  hbuf_ctrl dut (
    .clk_i                 (clk_i),
    .rst_ni                (rst_ni),
    .en_i                  (en_i),
    .start_pg_i            (start_pg_i),
    .stop_pg_i             (stop_pg_i),
    .first_pg_o            (first_pg_o),
    .last_pg_o             (last_pg_o),
    .flush_req_i           (flush_req_i),
    .flush_ack_o           (flush_ack_o),
    .empty_o               (empty_o),
    .full_o                (full_o),
    .rd_pg_num_o           (rd_pg_num_o),
    .wr_pg_num_o           (wr_pg_num_o),
    .n_used_pgs_o          (n_used_pgs_o),
    .pg_clr_cnt_i          (pg_clr_cnt_i),
    .pg_clr_req_i          (pg_clr_req_i),
    .pg_clr_ack_o          (pg_clr_ack_o),
    .buffered_data_o       (buffered_data_o),
    .dpram_len_i           (dpram_len_i),
    .rdout_dpram_run_i     (rdout_dpram_run_i),
    .dpram_busy_o          (dpram_busy_o),
    .rdout_dpram_wren_i    (rdout_dpram_wren_i),
    .rdout_dpram_wr_addr_i (rdout_dpram_wr_addr_i),
    .rdout_dpram_data_i    (rdout_dpram_data_i),
    .ddr3_dpram_rd_addr_i  (ddr3_dpram_rd_addr_i),
    .ddr3_dpram_dout_o     (ddr3_dpram_dout_o),
    .pg_req_o              (pg_req_o),
    .pg_ack_i              (pg_ack_i),
    .pg_optype_o           (pg_optype_o),
    .pg_addr_o             (pg_addr_o),
    .dbg_state_o           (dbg_state_o)
  );

  // Clock / watchdog
  always #5 clk_i = ~clk_i;

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Pulse run and wait for the copy to finish; ok=0 if it stays busy.
  task automatic run_record(output bit ok);
    rdout_dpram_run_i = 1'b1;
    tick();
    rdout_dpram_run_i = 1'b0;
    ok = 1'b0;
    for (int c = 0; c < 200; c++) begin
      if (!dpram_busy_o) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  // DDR3 side: ack each page request 10 cycles after it rises and check the
  // address against the scoreboard.
  initial begin
    pg_ack_i = 1'b0;
    forever begin
      tick();
      if (pg_req_o === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("pg_unexpected", 1'b1, 1'b0);
        end else begin
          chk("pg_addr", pg_addr_o, exp_q.pop_front());
        end
        chk("pg_optype", pg_optype_o, 1'b1);
        repeat (9) @(posedge clk_i);
        #1;
        pg_ack_i = 1'b1;
        tick();
        pg_ack_i = 1'b0;
        chk("pg_req_drop", pg_req_o, 1'b0);
      end
    end
  end

  initial begin
    bit ok;
    int rec;
    bit stalled;

    rst_ni = 1'b0;
    en_i = 1'b0;
    start_pg_i = '0;
    stop_pg_i = '0;
    flush_req_i = 1'b0;
    pg_clr_cnt_i = '0;
    pg_clr_req_i = 1'b0;
    dpram_len_i = '0;
    rdout_dpram_run_i = 1'b0;
    rdout_dpram_wren_i = 1'b0;
    rdout_dpram_wr_addr_i = '0;
    rdout_dpram_data_i = '0;
    ddr3_dpram_rd_addr_i = '0;

    // Expected commit order: 5..10, then 5 after the stall, then 6 by flush.
    for (int p = 5; p <= 10; p++) exp_q.push_back({16'(p), 12'h000});
    exp_q.push_back({16'd5, 12'h000});
    exp_q.push_back({16'd6, 12'h000});

    // Reset state
    repeat (3) tick();
    chk("rst_empty", empty_o, 1'b0);
    chk("rst_full", full_o, 1'b0);
    chk("rst_first", first_pg_o, 16'd0);
    chk("rst_pg_req", pg_req_o, 1'b0);
    chk("rst_busy", dpram_busy_o, 1'b0);
    chk("rst_dout", ddr3_dpram_dout_o, 128'd0);
    rst_ni = 1'b1;
    tick();

    // Load a 21-word ramp into the readout DPRAM
    for (int i = 0; i < 21; i++) begin
      rdout_dpram_wren_i = 1'b1;
      rdout_dpram_wr_addr_i = 10'(i);
      rdout_dpram_data_i = RAMP_BASE + 32'(i);
      tick();
    end
    rdout_dpram_wren_i = 1'b0;

    // Enable ring 5..10
    start_pg_i = 16'd5;
    stop_pg_i = 16'd10;
    en_i = 1'b1;
    tick();
    chk("en_first", first_pg_o, 16'd5);
    chk("en_last", last_pg_o, 16'd10);
    chk("en_rd", rd_pg_num_o, 16'd5);
    chk("en_wr", wr_pg_num_o, 16'd5);
    chk("en_empty", empty_o, 1'b1);
    chk("en_full", full_o, 1'b0);

    // First record and page buffer readback
    dpram_len_i = 16'd21;
    run_record(ok);
    chk("rec0_done", ok, 1'b1);
    chk("rec0_buffered", buffered_data_o, 1'b1);
    ddr3_dpram_rd_addr_i = 8'd0;
    tick();
    chk("dout_w0", ddr3_dpram_dout_o[31:0], RAMP_BASE);
    chk("dout_w1", ddr3_dpram_dout_o[63:32], RAMP_BASE + 32'd1);

    // Second record: 128-bit word 5 straddles the two records
    run_record(ok);
    chk("rec1_done", ok, 1'b1);
    ddr3_dpram_rd_addr_i = 8'd5;
    tick();
    chk("dout_straddle", ddr3_dpram_dout_o,
        {RAMP_BASE + 32'd2, RAMP_BASE + 32'd1, RAMP_BASE, RAMP_BASE + 32'd20});

    // Keep copying until the writer stalls on a full ring. Page 7 completes
    // at word 7168, inside record index 341.
    rec = 2;
    stalled = 1'b0;
    while (rec < 400 && !stalled) begin
      run_record(ok);
      if (!ok) stalled = 1'b1;
      else rec++;
    end
    chk("stall_rec", 32'(rec), 32'd341);
    chk("stall_wr", wr_pg_num_o, 16'd5);
    chk("stall_rd", rd_pg_num_o, 16'd5);
    chk("stall_nused", n_used_pgs_o, 16'd6);
    chk("stall_full", full_o, 1'b1);
    chk("stall_busy", dpram_busy_o, 1'b1);
    chk("stall_no_req", pg_req_o, 1'b0);

    // Release one page
    pg_clr_cnt_i = 16'd1;
    pg_clr_req_i = 1'b1;
    tick();
    chk("clr1_ack", pg_clr_ack_o, 1'b1);
    chk("clr1_rd", rd_pg_num_o, 16'd6);
    chk("clr1_nused", n_used_pgs_o, 16'd5);
    chk("clr1_full", full_o, 1'b0);
    tick();
    chk("clr1_ack_pulse", pg_clr_ack_o, 1'b0);
    chk("clr1_nused_hold", n_used_pgs_o, 16'd5);
    pg_clr_req_i = 1'b0;

    // Stalled page commits, the remaining 14 words of the record land
    ok = 1'b0;
    for (int c = 0; c < 200; c++) begin
      if (!dpram_busy_o) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    chk("resume_done", ok, 1'b1);
    chk("resume_wr", wr_pg_num_o, 16'd6);
    chk("resume_nused", n_used_pgs_o, 16'd6);
    chk("resume_full", full_o, 1'b1);
    chk("resume_buffered", buffered_data_o, 1'b1);

    // Oversized clear is clamped to the used page count
    pg_clr_cnt_i = 16'd1000;
    pg_clr_req_i = 1'b1;
    tick();
    chk("clr_big_ack", pg_clr_ack_o, 1'b1);
    chk("clr_big_rd", rd_pg_num_o, 16'd6);
    chk("clr_big_nused", n_used_pgs_o, 16'd0);
    chk("clr_big_empty", empty_o, 1'b1);
    pg_clr_req_i = 1'b0;
    tick();

    // Flush the partial page
    flush_req_i = 1'b1;
    ok = 1'b0;
    for (int c = 0; c < 100; c++) begin
      tick();
      if (flush_ack_o) begin
        ok = 1'b1;
        break;
      end
    end
    chk("flush_ack", ok, 1'b1);
    chk("flush_buffered", buffered_data_o, 1'b0);
    chk("flush_wr", wr_pg_num_o, 16'd7);
    chk("flush_nused", n_used_pgs_o, 16'd1);
    chk("flush_req_low", pg_req_o, 1'b0);
    tick();
    chk("flush_ack_pulse", flush_ack_o, 1'b0);

    // Flush with an empty page buffer acks next cycle
    flush_req_i = 1'b0;
    tick();
    flush_req_i = 1'b1;
    tick();
    chk("flush_empty_ack", flush_ack_o, 1'b1);
    chk("flush_empty_nused", n_used_pgs_o, 16'd1);
    flush_req_i = 1'b0;
    tick();

    // Disabled ring: record is accepted and discarded after one busy cycle
    en_i = 1'b0;
    tick();
    rdout_dpram_run_i = 1'b1;
    tick();
    rdout_dpram_run_i = 1'b0;
    chk("drop_busy", dpram_busy_o, 1'b1);
    tick();
    chk("drop_idle", dpram_busy_o, 1'b0);
    chk("drop_buffered", buffered_data_o, 1'b0);
    chk("drop_nused", n_used_pgs_o, 16'd1);
    chk("pages_left", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
